data_mem_access_controller: RTL and testbench
=============================================

Name: data_mem_access_controller

Overview:
Sequencer and arbiter in front of the single-port 1024x32 data RAM, which has a 1-cycle synchronous read and no byte enables. It serves MEM-stage loads/stores and implements sub-word stores as read-modify-write, stalling the pipeline as needed. It also grants a read-only debug port access to the RAM when the pipeline is idle.

Parameters:
Width_B, 32, data word width
Addr_B, 32, pipeline byte-address width
MemAddr_B, 10, RAM word-address width

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-low reset
req_valid  in  1  MEM-stage access request; held stable while stall=1
req_write  in  1  1=store, 0=load
req_addr  in  Addr_B  byte address (base+offset)
req_wdata  in  Width_B  store data, right-aligned
req_mode  in  2  00 word, 01 half, 10 byte, 11 treated as word
stall  out  1  pipeline must hold the request
rd_valid  out  1  load completes this cycle
rd_data  out  Width_B  extracted load data, zero-extended
mem_we  out  1  RAM write enable
mem_addr  out  MemAddr_B  RAM word address
mem_din  out  Width_B  RAM write data
mem_dout  in  Width_B  RAM read data, valid 1 cycle after address
dbg_req  in  1  debug read request, level
dbg_addr  in  MemAddr_B  debug word address
dbg_ack  out  1  debug data valid this cycle
dbg_rdata  out  Width_B  debug read data

Behaviour:
- Word address = req_addr[11:2]; lane = req_addr[1:0]; little-endian (lane 0 = bits[7:0]). Half uses req_addr[1] only (req_addr[0] ignored). Upper req_addr bits are ignored; no range check.
- States: IDLE, LD_WAIT, RMW_RD, RMW_WR, DBG_WAIT.
- IDLE, req_valid, word store: mem_we=1, mem_din=req_wdata, stall=0; completes in 1 cycle; stay IDLE.
- IDLE, req_valid, load: drive mem_addr, stall=1 -> LD_WAIT. LD_WAIT: rd_valid=1, rd_data=lane extract of mem_dout, stall=0 -> IDLE. Load latency is 2 cycles.
- IDLE, req_valid, half/byte store: drive mem_addr, stall=1 -> RMW_RD. RMW_RD: register merged word (mem_dout with selected lane(s) replaced by req_wdata[7:0]/[15:0]), stall=1 -> RMW_WR. RMW_WR: mem_we=1, mem_din=merged, stall=0 -> IDLE. Latency is 3 cycles.
- mem_addr is driven from req_addr in every pipeline state; the request is stable.
- Arbitration: pipeline has absolute priority. In IDLE with req_valid=0 and dbg_req=1: mem_addr=dbg_addr -> DBG_WAIT. DBG_WAIT: dbg_ack=1, dbg_rdata=mem_dout -> IDLE. If req_valid=1 during DBG_WAIT, stall=1 that cycle and the request is served from IDLE next cycle. Debug may starve under continuous pipeline traffic; this is accepted.
- stall is combinational: 1 in IDLE for load/sub-word requests, 1 in RMW_RD, 1 in DBG_WAIT when req_valid, else 0. stall=0 whenever req_valid=0 in IDLE.
- rd_data/dbg_rdata are 0 when their valid/ack is low. mem_din is 0 when mem_we=0.
- Reset (reset=0): state IDLE; stall, rd_valid, rd_data, mem_we, mem_din, dbg_ack, dbg_rdata, and the merged register are all 0. mem_we is forced 0 during reset. A reset in RMW_RD/RMW_WR aborts with no write, so the RAM is unchanged.
- Back-to-back requests: the request following a completion cycle is accepted in IDLE on the next cycle; there are no bubbles beyond the stated latencies.

Test Plan:
- Word store addr 0x10, data 0xDEADBEEF, then load word 0x10 -> mem_we at word 4 in 1 cycle, stall=0; load: stall 1 cycle, rd_valid with rd_data=0xDEADBEEF.
- RAM word 4=0x11223344; byte store 0xAA to addr 0x12 -> stall 2 cycles, then mem_we with mem_din=0x11AA3344; byte load 0x12 -> rd_data=0x000000AA.
- Half store 0xBEEF to addr 0x13 (word 0x11223344) -> addr[0] ignored, mem_din=0xBEEF3344; half load 0x10 -> 0x00003344.
- dbg_req=1, dbg_addr=4, pipeline idle -> dbg_ack 1 cycle later with 0x11223344; a req_valid load arriving in DBG_WAIT -> stall=1 that cycle, load completes 2 cycles later.
- Continuous loads with dbg_req=1 -> dbg_ack never asserted; pipeline loads complete every 2 cycles.
- reset=0 asserted in RMW_RD of byte store to word 4 -> no mem_we; outputs 0; word 4 unchanged on readback.

Source files
------------

// File: rtl/data_mem_access_controller_if.sv
// Bundles the pipeline request, debug read and RAM signals of the data memory controller.
// The controller takes the slave view; the pipeline, debug port and RAM take the master view.
interface data_mem_access_controller_if #(
   parameter int Width_B   = 32,
   parameter int Addr_B    = 32,
   parameter int MemAddr_B = 10
);
   logic                 req_valid;
   logic                 req_write;
   logic [Addr_B-1:0]    req_addr;
   logic [Width_B-1:0]   req_wdata;
   logic [1:0]           req_mode;
   logic                 stall;
   logic                 rd_valid;
   logic [Width_B-1:0]   rd_data;
   logic                 mem_we;
   logic [MemAddr_B-1:0] mem_addr;
   logic [Width_B-1:0]   mem_din;
   logic [Width_B-1:0]   mem_dout;
   logic                 dbg_req;
   logic [MemAddr_B-1:0] dbg_addr;
   logic                 dbg_ack;
   logic [Width_B-1:0]   dbg_rdata;

   modport master (
      output req_valid, req_write, req_addr, req_wdata, req_mode, mem_dout, dbg_req, dbg_addr,
      input  stall, rd_valid, rd_data, mem_we, mem_addr, mem_din, dbg_ack, dbg_rdata
   );

   modport slave (
      input  req_valid, req_write, req_addr, req_wdata, req_mode, mem_dout, dbg_req, dbg_addr,
      output stall, rd_valid, rd_data, mem_we, mem_addr, mem_din, dbg_ack, dbg_rdata
   );
endinterface

// File: rtl/data_mem_access_controller.sv
// Arbitrates one sync-read RAM between MEM-stage loads/stores (sub-word stores as read-modify-write) and a debug reader.
// Word store 1 cycle, load 2, sub-word store 3; stall holds the pipeline; debug is served only when the pipeline is idle.
module data_mem_access_controller #(
   parameter int Width_B   = 32,
   parameter int Addr_B    = 32,
   parameter int MemAddr_B = 10
) (
   input  logic clk,
   input  logic reset,
   data_mem_access_controller_if.slave bus
);
   typedef enum logic [2:0] {IDLE, LD_WAIT, RMW_RD, RMW_WR, DBG_WAIT} state_t;

   state_t               state_q, state_d;
   logic [Width_B-1:0]   merged_q, merged_d;
   logic [MemAddr_B-1:0] word_addr;
   logic [1:0]           lane;
   logic                 sub_word;
   logic [Width_B-1:0]   load_data, merge_data;
   logic                 stall_c, we_c, rd_valid_c, ack_c;
   logic [Width_B-1:0]   din_c, rd_data_c, dbg_data_c;
   logic [MemAddr_B-1:0] addr_c;
   logic                 unused_addr_bits;

   assign word_addr        = bus.req_addr[MemAddr_B+1:2];
   assign lane             = bus.req_addr[1:0];
   assign sub_word         = (bus.req_mode == 2'b01) || (bus.req_mode == 2'b10);
   assign unused_addr_bits = ^{bus.req_addr[Addr_B-1:MemAddr_B+2]};

   // Half-word accesses select the lane pair with addr[1] only.
   always_comb begin
      load_data  = '0;
      merge_data = bus.mem_dout;
      case (bus.req_mode)
         2'b01: begin
            load_data[15:0] = bus.mem_dout[{lane[1], 4'b0000} +: 16];
            merge_data[{lane[1], 4'b0000} +: 16] = bus.req_wdata[15:0];
         end
         2'b10: begin
            load_data[7:0] = bus.mem_dout[{lane, 3'b000} +: 8];
            merge_data[{lane, 3'b000} +: 8] = bus.req_wdata[7:0];
         end
         default: load_data = bus.mem_dout;
      endcase
   end

   always_comb begin
      state_d    = state_q;
      merged_d   = merged_q;
      stall_c    = 1'b0;
      we_c       = 1'b0;
      din_c      = '0;
      addr_c     = word_addr;
      rd_valid_c = 1'b0;
      rd_data_c  = '0;
      ack_c      = 1'b0;
      dbg_data_c = '0;
      case (state_q)
         IDLE: begin
            if (bus.req_valid) begin
               if (bus.req_write && !sub_word) begin
                  we_c  = 1'b1;
                  din_c = bus.req_wdata;
               end else begin
                  stall_c = 1'b1;
                  state_d = bus.req_write ? RMW_RD : LD_WAIT;
               end
            end else if (bus.dbg_req) begin
               addr_c  = bus.dbg_addr;
               state_d = DBG_WAIT;
            end
         end
         LD_WAIT: begin
            rd_valid_c = 1'b1;
            rd_data_c  = load_data;
            state_d    = IDLE;
         end
         RMW_RD: begin
            stall_c  = 1'b1;
            merged_d = merge_data;
            state_d  = RMW_WR;
         end
         RMW_WR: begin
            we_c    = 1'b1;
            din_c   = merged_q;
            state_d = IDLE;
         end
         DBG_WAIT: begin
            ack_c      = 1'b1;
            dbg_data_c = bus.mem_dout;
            stall_c    = bus.req_valid;
            state_d    = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q  <= IDLE;
         merged_q <= '0;
      end else begin
         state_q  <= state_d;
         merged_q <= merged_d;
      end
   end

   // Gating with reset keeps an aborted read-modify-write from reaching the RAM.
   assign bus.stall     = stall_c & reset;
   assign bus.mem_we    = we_c & reset;
   assign bus.mem_din   = reset ? din_c : '0;
   assign bus.mem_addr  = addr_c;
   assign bus.rd_valid  = rd_valid_c & reset;
   assign bus.rd_data   = reset ? rd_data_c : '0;
   assign bus.dbg_ack   = ack_c & reset;
   assign bus.dbg_rdata = reset ? dbg_data_c : '0;
endmodule

// File: tb/tb_data_mem_access_controller.sv
// Directed bench for the data memory controller with a word-level memory model and a per-cycle output checker.
module tb_data_mem_access_controller;
   logic clk;
   logic reset;

   data_mem_access_controller_if #(.Width_B(32), .Addr_B(32), .MemAddr_B(10)) bus ();

   data_mem_access_controller #(.Width_B(32), .Addr_B(32), .MemAddr_B(10)) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [31:0] ram [1024];
   logic [31:0] ref_mem [1024];

   always @(posedge clk) begin
      if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_din;
      bus.mem_dout <= ram[bus.mem_addr];
   end

   int n_checks = 0;
   int n_err    = 0;

   logic        chk_en;
   logic        exp_stall, exp_rd_valid, exp_we, exp_ack;
   logic [31:0] exp_rd_data, exp_din, exp_dbg_data;
   logic [9:0]  exp_addr;
   logic [31:0] last_rd, last_din, last_dbg;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s at %0t: got=%h want=%h", name, $time, got, want);
      end
   endtask

   function automatic logic [31:0] lane_extract(input logic [31:0] w, input logic [31:0] a,
                                               input logic [1:0] m);
      case (m)
         2'b01:   return (w >> (a[1] * 16)) & 32'h0000FFFF;
         2'b10:   return (w >> (a[1:0] * 8)) & 32'h000000FF;
         default: return w;
      endcase
   endfunction

   function automatic logic [31:0] lane_merge(input logic [31:0] w, input logic [31:0] a,
                                             input logic [1:0] m, input logic [31:0] d);
      logic [31:0] mask;
      int          sh;
      if (m == 2'b01) begin
         mask = 32'h0000FFFF;
         sh   = a[1] * 16;
      end else begin
         mask = 32'h000000FF;
         sh   = a[1:0] * 8;
      end
      return (w & ~(mask << sh)) | ((d & mask) << sh);
   endfunction

   always @(negedge clk) begin
      if (chk_en) begin
         check("stall", {31'b0, bus.stall}, {31'b0, exp_stall});
         check("rd_valid", {31'b0, bus.rd_valid}, {31'b0, exp_rd_valid});
         check("rd_data", bus.rd_data, exp_rd_data);
         check("mem_we", {31'b0, bus.mem_we}, {31'b0, exp_we});
         check("mem_din", bus.mem_din, exp_din);
         check("dbg_ack", {31'b0, bus.dbg_ack}, {31'b0, exp_ack});
         check("dbg_rdata", bus.dbg_rdata, exp_dbg_data);
         if (exp_we) check("mem_addr", {22'b0, bus.mem_addr}, {22'b0, exp_addr});
      end
      if (bus.rd_valid) last_rd = bus.rd_data;
      if (bus.mem_we) last_din = bus.mem_din;
      if (bus.dbg_ack) last_dbg = bus.dbg_rdata;
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_exp();
      exp_stall    = 1'b0;
      exp_rd_valid = 1'b0;
      exp_rd_data  = '0;
      exp_we       = 1'b0;
      exp_din      = '0;
      exp_addr     = '0;
      exp_ack      = 1'b0;
      exp_dbg_data = '0;
   endtask

   task automatic drive_req(input logic v, input logic w, input logic [31:0] a,
                            input logic [31:0] d, input logic [1:0] m);
      bus.req_valid = v;
      bus.req_write = w;
      bus.req_addr  = a;
      bus.req_wdata = d;
      bus.req_mode  = m;
   endtask

   task automatic idle();
      drive_req(1'b0, 1'b0, 32'h0, 32'h0, 2'b00);
      bus.dbg_req = 1'b0;
      clear_exp();
      cyc();
   endtask

   task automatic store_word(input logic [31:0] a, input logic [31:0] d);
      drive_req(1'b1, 1'b1, a, d, 2'b00);
      clear_exp();
      exp_we   = 1'b1;
      exp_din  = d;
      exp_addr = a[11:2];
      cyc();
      ref_mem[a[11:2]] = d;
   endtask

   task automatic sub_store(input logic [31:0] a, input logic [1:0] m, input logic [31:0] d,
                            input logic [31:0] lit);
      logic [31:0] merged;
      merged   = lane_merge(ref_mem[a[11:2]], a, m, d);
      last_din = 32'hBAD0BAD0;
      drive_req(1'b1, 1'b1, a, d, m);
      clear_exp();
      exp_stall = 1'b1;
      cyc();
      cyc();
      clear_exp();
      exp_we   = 1'b1;
      exp_din  = merged;
      exp_addr = a[11:2];
      cyc();
      ref_mem[a[11:2]] = merged;
      check("sub_store_literal", last_din, lit);
   endtask

   // Request cycle then completion cycle; dbg_req is left as the caller set it.
   task automatic do_load(input logic [31:0] a, input logic [1:0] m, input logic [31:0] lit);
      last_rd = 32'hBAD0BAD0;
      drive_req(1'b1, 1'b0, a, 32'h0, m);
      clear_exp();
      exp_stall = 1'b1;
      cyc();
      clear_exp();
      exp_rd_valid = 1'b1;
      exp_rd_data  = lane_extract(ref_mem[a[11:2]], a, m);
      cyc();
      check("load_literal", last_rd, lit);
   endtask

   logic [31:0] ld_addr [6];
   logic [1:0]  ld_mode [6];
   logic [31:0] ld_lit  [6];

   initial begin
      for (int i = 0; i < 1024; i++) begin
         ram[i]     = '0;
         ref_mem[i] = '0;
      end
      chk_en       = 1'b0;
      reset        = 1'b0;
      bus.dbg_req  = 1'b0;
      bus.dbg_addr = '0;
      drive_req(1'b0, 1'b0, 32'h0, 32'h0, 2'b00);
      clear_exp();
      cyc();
      chk_en = 1'b1;
      // Reset held with a load request pending: everything must stay quiet.
      drive_req(1'b1, 1'b0, 32'h10, 32'h0, 2'b00);
      cyc();
      cyc();
      reset = 1'b1;
      idle();

      store_word(32'h10, 32'hDEADBEEF);
      do_load(32'h10, 2'b00, 32'hDEADBEEF);

      store_word(32'h10, 32'h11223344);
      sub_store(32'h12, 2'b10, 32'h000000AA, 32'h11AA3344);
      do_load(32'h12, 2'b10, 32'h000000AA);

      store_word(32'h10, 32'h11223344);
      sub_store(32'h13, 2'b01, 32'h0000BEEF, 32'hBEEF3344);
      do_load(32'h10, 2'b01, 32'h00003344);

      store_word(32'h10, 32'h11223344);
      idle();

      // Plain debug read while the pipeline is idle.
      last_dbg     = 32'hBAD0BAD0;
      bus.dbg_req  = 1'b1;
      bus.dbg_addr = 10'd4;
      clear_exp();
      cyc();
      bus.dbg_req  = 1'b0;
      clear_exp();
      exp_ack      = 1'b1;
      exp_dbg_data = ref_mem[4];
      cyc();
      check("dbg_literal", last_dbg, 32'h11223344);
      idle();

      // A load arriving while the debug read is completing is stalled one cycle.
      bus.dbg_req  = 1'b1;
      bus.dbg_addr = 10'd4;
      clear_exp();
      cyc();
      bus.dbg_req = 1'b0;
      drive_req(1'b1, 1'b0, 32'h10, 32'h0, 2'b00);
      clear_exp();
      exp_stall    = 1'b1;
      exp_ack      = 1'b1;
      exp_dbg_data = ref_mem[4];
      cyc();
      do_load(32'h10, 2'b00, 32'h11223344);

      // Back-to-back traffic with debug held: debug never wins.
      store_word(32'h20, 32'hCAFEF00D);
      ld_addr = '{32'h20, 32'h21, 32'h22, 32'h10, 32'h13, 32'h20};
      ld_mode = '{2'b00, 2'b10, 2'b01, 2'b11, 2'b10, 2'b01};
      ld_lit  = '{32'hCAFEF00D, 32'h000000F0, 32'h0000CAFE, 32'h11223344, 32'h00000011, 32'h0000F00D};
      bus.dbg_req  = 1'b1;
      bus.dbg_addr = 10'd4;
      for (int i = 0; i < 6; i++) do_load(ld_addr[i], ld_mode[i], ld_lit[i]);
      idle();

      // Reset during the read phase of a byte store aborts it.
      drive_req(1'b1, 1'b1, 32'h11, 32'h00000055, 2'b10);
      clear_exp();
      exp_stall = 1'b1;
      cyc();
      reset = 1'b0;
      clear_exp();
      cyc();
      drive_req(1'b0, 1'b0, 32'h0, 32'h0, 2'b00);
      cyc();
      reset = 1'b1;
      idle();
      idle();
      check("ram_w4_after_abort", ram[4], 32'h11223344);
      do_load(32'h10, 2'b00, 32'h11223344);
      idle();

      chk_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end
endmodule
